// File: rtl/cdp1802_pkg.sv
// Shared CDP1802 constants: state-code encoding and default
// machine-cycle timing used by the CPU core and the CDP1861 block.
package cdp1802_pkg;

   localparam logic [1:0] SC_FETCH = 2'd0;
   localparam logic [1:0] SC_EXEC  = 2'd1;
   localparam logic [1:0] SC_DMA   = 2'd2;
   localparam logic [1:0] SC_INT   = 2'd3;

   localparam int DEF_PHASES    = 8;
   localparam int DEF_TPA_PHASE = 1;
   localparam int DEF_TPB_PHASE = 6;

endpackage

// File: rtl/cdp1802_phase_gen.sv
// Phase counter for one machine cycle, with registered TPA/TPB/cycle_end.
// Ports: clock, reset (sync, active-low), ce; outputs tpa, tpb,
// cycle_end (registered) and wrap/sample strobes (combinational, ce-gated).
module cdp1802_phase_gen
   import cdp1802_pkg::*;
#(
   parameter int PHASES    = DEF_PHASES,
   parameter int TPA_PHASE = DEF_TPA_PHASE,
   parameter int TPB_PHASE = DEF_TPB_PHASE
) (
   input  logic clock,
   input  logic reset,
   input  logic ce,
   output logic tpa,
   output logic tpb,
   output logic cycle_end,
   output logic wrap,
   output logic sample
);

   localparam int PW = $clog2(PHASES);
   localparam logic [PW-1:0] LAST  = PW'(PHASES - 1);
   localparam logic [PW-1:0] TPA_P = PW'(TPA_PHASE);
   localparam logic [PW-1:0] TPB_P = PW'(TPB_PHASE);

   logic [PW-1:0] phase;
   logic [PW-1:0] phase_next;

   assign phase_next = (phase == LAST) ? '0 : phase + PW'(1);
   assign wrap       = ce && (phase == LAST);
   assign sample     = ce && (phase == TPB_P);

   // Pulses are decoded from the next phase so they line up
   // exactly with the ce-period of their phase.
   always_ff @(posedge clock) begin
      if (!reset) begin
         phase     <= '0;
         tpa       <= 1'b0;
         tpb       <= 1'b0;
         cycle_end <= 1'b0;
      end else if (ce) begin
         phase     <= phase_next;
         tpa       <= (phase_next == TPA_P);
         tpb       <= (phase_next == TPB_P);
         cycle_end <= (phase_next == LAST);
      end
   end

endmodule

// File: rtl/cdp1802_cycle_sequencer.sv
// CDP1802 machine-cycle sequencer: phases, SC state code and DMA/INT arbitration.
// Ports: clock, reset, ce, dma_in_n, dma_out_n, int_n, ie, exec_long, idle_req
// in; sc, tpa, tpb, dma_in_cycle, dma_out_cycle, int_ack, ie_clear,
// cycle_end, idle out (all registered).
module cdp1802_cycle_sequencer
   import cdp1802_pkg::*;
#(
   parameter int PHASES    = DEF_PHASES,
   parameter int TPA_PHASE = DEF_TPA_PHASE,
   parameter int TPB_PHASE = DEF_TPB_PHASE
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ce,
   input  logic       dma_in_n,
   input  logic       dma_out_n,
   input  logic       int_n,
   input  logic       ie,
   input  logic       exec_long,
   input  logic       idle_req,
   output logic [1:0] sc,
   output logic       tpa,
   output logic       tpb,
   output logic       dma_in_cycle,
   output logic       dma_out_cycle,
   output logic       int_ack,
   output logic       ie_clear,
   output logic       cycle_end,
   output logic       idle
);

   logic       wrap;
   logic       sample;
   logic       dma_in_req;
   logic       dma_out_req;
   logic       int_req;
   logic       long_done;
   logic       dma_any;
   logic [1:0] sc_next;
   logic       idle_next;
   logic       long_next;

   cdp1802_phase_gen #(
      .PHASES    (PHASES),
      .TPA_PHASE (TPA_PHASE),
      .TPB_PHASE (TPB_PHASE)
   ) u_phase (
      .clock     (clock),
      .reset     (reset),
      .ce        (ce),
      .tpa       (tpa),
      .tpb       (tpb),
      .cycle_end (cycle_end),
      .wrap      (wrap),
      .sample    (sample)
   );

   assign dma_any = dma_in_req | dma_out_req;

   always_comb begin
      sc_next   = SC_FETCH;
      idle_next = 1'b0;
      long_next = 1'b0;
      unique case (sc)
         SC_FETCH: sc_next = SC_EXEC;
         SC_EXEC: begin
            if (idle) begin
               if (dma_any)      sc_next = SC_DMA;
               else if (int_req) sc_next = SC_INT;
               else begin
                  sc_next   = SC_EXEC;
                  idle_next = 1'b1;
               end
            end else if (exec_long && !long_done) begin
               sc_next   = SC_EXEC;
               long_next = 1'b1;
            end else if (dma_any) begin
               sc_next = SC_DMA;
            end else if (int_req) begin
               sc_next = SC_INT;
            end else if (idle_req) begin
               sc_next   = SC_EXEC;
               idle_next = 1'b1;
            end
         end
         SC_DMA: begin
            if (dma_any)      sc_next = SC_DMA;
            else if (int_req) sc_next = SC_INT;
         end
         SC_INT: begin
            if (dma_any) sc_next = SC_DMA;
         end
         default: sc_next = SC_FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         sc            <= SC_FETCH;
         idle          <= 1'b0;
         long_done     <= 1'b0;
         dma_in_req    <= 1'b0;
         dma_out_req   <= 1'b0;
         int_req       <= 1'b0;
         dma_in_cycle  <= 1'b0;
         dma_out_cycle <= 1'b0;
         int_ack       <= 1'b0;
         ie_clear      <= 1'b0;
      end else if (ce) begin
         int_ack  <= 1'b0;
         ie_clear <= 1'b0;
         if (sample) begin
            dma_in_req  <= ~dma_in_n;
            dma_out_req <= ~dma_out_n;
            int_req     <= ~int_n & ie;
         end
         if (wrap) begin
            sc        <= sc_next;
            idle      <= idle_next;
            long_done <= long_next;
            // dma_in wins when both are pending
            dma_in_cycle  <= (sc_next == SC_DMA) & dma_in_req;
            dma_out_cycle <= (sc_next == SC_DMA) & ~dma_in_req & dma_out_req;
            int_ack       <= (sc_next == SC_INT);
            ie_clear      <= (sc_next == SC_INT);
         end
      end
   end

endmodule

// File: tb/tb_cdp1802_cycle_sequencer.sv
// Directed bench for cdp1802_cycle_sequencer with hand-computed cycle sequences.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cdp1802_cycle_sequencer;

   logic       clock;
   logic       reset;
   logic       ce;
   logic       dma_in_n;
   logic       dma_out_n;
   logic       int_n;
   logic       ie;
   logic       exec_long;
   logic       idle_req;
   logic [1:0] sc;
   logic       tpa;
   logic       tpb;
   logic       dma_in_cycle;
   logic       dma_out_cycle;
   logic       int_ack;
   logic       ie_clear;
   logic       cycle_end;
   logic       idle;

   int checks = 0;
   int errors = 0;

   cdp1802_cycle_sequencer dut (
      .clock         (clock),
      .reset         (reset),
      .ce            (ce),
      .dma_in_n      (dma_in_n),
      .dma_out_n     (dma_out_n),
      .int_n         (int_n),
      .ie            (ie),
      .exec_long     (exec_long),
      .idle_req      (idle_req),
      .sc            (sc),
      .tpa           (tpa),
      .tpb           (tpb),
      .dma_in_cycle  (dma_in_cycle),
      .dma_out_cycle (dma_out_cycle),
      .int_ack       (int_ack),
      .ie_clear      (ie_clear),
      .cycle_end     (cycle_end),
      .idle          (idle)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic steps(input int n);
      repeat (n) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   initial begin
      reset     = 1'b0;
      ce        = 1'b1;
      dma_in_n  = 1'b1;
      dma_out_n = 1'b1;
      int_n     = 1'b1;
      ie        = 1'b0;
      exec_long = 1'b0;
      idle_req  = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);

      check("rst_sc", 32'(sc), 0);
      check("rst_tpa", 32'(tpa), 0);
      check("rst_tpb", 32'(tpb), 0);
      check("rst_end", 32'(cycle_end), 0);
      check("rst_idle", 32'(idle), 0);
      check("rst_dmain", 32'(dma_in_cycle), 0);
      check("rst_dmaout", 32'(dma_out_cycle), 0);
      check("rst_iack", 32'(int_ack), 0);
      check("rst_iec", 32'(ie_clear), 0);
      reset = 1'b1;

      // plain instruction flow: S0,S1,S0,S1 with pulse positions
      for (int c = 0; c < 4; c++) begin
         for (int p = 0; p < 8; p++) begin
            check("alt_sc", 32'(sc), 32'(c % 2));
            check("alt_tpa", 32'(tpa), 32'(p == 1));
            check("alt_tpb", 32'(tpb), 32'(p == 6));
            check("alt_end", 32'(cycle_end), 32'(p == 7));
            steps(1);
         end
      end

      // cycle 4: S0, hold ce low while tpa is high
      check("s0_c4", 32'(sc), 0);
      steps(1);
      ce = 1'b0;
      steps(3);
      check("ce_tpa", 32'(tpa), 1);
      check("ce_sc", 32'(sc), 0);
      ce = 1'b1;
      steps(1);
      check("ce_tpa2", 32'(tpa), 0);
      steps(3);
      dma_out_n = 1'b0;
      steps(3);

      // DMA-out held: S1 then three S2 then S0
      check("dma_s1", 32'(sc), 1);
      steps(8);
      for (int k = 0; k < 3; k++) begin
         check("dma_sc", 32'(sc), 2);
         check("dma_out", 32'(dma_out_cycle), 1);
         check("dma_in0", 32'(dma_in_cycle), 0);
         if (k == 2) begin
            steps(2);
            dma_out_n = 1'b1;
            steps(6);
         end else begin
            steps(8);
         end
      end
      check("dma_s0", 32'(sc), 0);
      check("dma_off", 32'(dma_out_cycle), 0);
      steps(8);

      // interrupt during execute
      check("int_s1", 32'(sc), 1);
      int_n = 1'b0;
      ie    = 1'b1;
      steps(8);
      check("int_s3", 32'(sc), 3);
      check("int_ack", 32'(int_ack), 1);
      check("int_iec", 32'(ie_clear), 1);
      ie = 1'b0;
      steps(1);
      check("int_ack0", 32'(int_ack), 0);
      check("int_iec0", 32'(ie_clear), 0);
      steps(7);
      check("int_s0", 32'(sc), 0);
      steps(8);
      check("ie0_s1", 32'(sc), 1);
      steps(8);
      check("ie0_no_s3", 32'(sc), 0);
      int_n = 1'b1;
      steps(8);

      // both DMA requests plus interrupt
      check("pri_s1", 32'(sc), 1);
      dma_in_n  = 1'b0;
      dma_out_n = 1'b0;
      int_n     = 1'b0;
      ie        = 1'b1;
      steps(8);
      check("pri_sc1", 32'(sc), 2);
      check("pri_in1", 32'(dma_in_cycle), 1);
      check("pri_out1", 32'(dma_out_cycle), 0);
      steps(8);
      check("pri_sc2", 32'(sc), 2);
      check("pri_in2", 32'(dma_in_cycle), 1);
      steps(1);
      dma_in_n = 1'b1;
      steps(7);
      check("pri_sc3", 32'(sc), 2);
      check("pri_in3", 32'(dma_in_cycle), 0);
      check("pri_out3", 32'(dma_out_cycle), 1);
      steps(1);
      dma_out_n = 1'b1;
      steps(7);
      check("pri_s3", 32'(sc), 3);
      check("pri_ack", 32'(int_ack), 1);
      check("pri_dma0", 32'(dma_out_cycle), 0);
      ie    = 1'b0;
      int_n = 1'b1;
      steps(8);
      check("pri_s0", 32'(sc), 0);
      steps(8);

      // idle: park in S1, DMA pulse breaks out
      check("idl_s1", 32'(sc), 1);
      check("idl_0", 32'(idle), 0);
      idle_req = 1'b1;
      steps(8);
      for (int k = 0; k < 5; k++) begin
         check("idl_sc", 32'(sc), 1);
         check("idl_1", 32'(idle), 1);
         if (k == 4) begin
            steps(5);
            dma_out_n = 1'b0;
            steps(2);
            dma_out_n = 1'b1;
            steps(1);
         end else begin
            steps(8);
         end
      end
      check("idl_s2", 32'(sc), 2);
      check("idl_clr", 32'(idle), 0);
      check("idl_dout", 32'(dma_out_cycle), 1);
      idle_req = 1'b0;
      steps(8);
      check("idl_s0", 32'(sc), 0);
      check("idl_clr2", 32'(idle), 0);

      // long instruction: two execute cycles only
      exec_long = 1'b1;
      steps(8);
      check("lng_s1a", 32'(sc), 1);
      steps(8);
      check("lng_s1b", 32'(sc), 1);
      steps(8);
      check("lng_s0", 32'(sc), 0);
      exec_long = 1'b0;
      steps(8);

      // reset in the middle of an S2
      check("rmid_s1", 32'(sc), 1);
      dma_out_n = 1'b0;
      steps(8);
      check("rmid_s2", 32'(sc), 2);
      steps(4);
      reset = 1'b0;
      steps(1);
      check("rmid_sc", 32'(sc), 0);
      check("rmid_tpa", 32'(tpa), 0);
      check("rmid_tpb", 32'(tpb), 0);
      check("rmid_dout", 32'(dma_out_cycle), 0);
      reset     = 1'b1;
      dma_out_n = 1'b1;
      check("post_s0", 32'(sc), 0);
      steps(8);
      check("post_s1", 32'(sc), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdp1802_cycle_sequencer.md
# cdp1802_cycle_sequencer

Machine-cycle sequencer for the CDP1802 core. It divides the clock into 8-phase machine cycles and generates the TPA/TPB timing pulses. It also drives the state code SC consumed by the CDP1861 video block. Between cycles it arbitrates among instruction flow, DMA requests (the CDP1861 DMA-out request plus the DMA-in request) and interrupt requests (the CDP1861 INT plus others), choosing the next cycle type.

## Interface
Parameters:
- PHASES, 8, clock-enabled ticks per machine cycle (≥4)
- TPA_PHASE, 1, phase index at which TPA is high
- TPB_PHASE, 6, phase index at which TPB is high; requests are sampled here

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- ce  in  1  phase advance enable
- dma_in_n  in  1  DMA-in request, active-low
- dma_out_n  in  1  DMA-out request, active-low (from CDP1861 DMAO)
- int_n  in  1  interrupt request, active-low (from CDP1861 INT)
- ie  in  1  CPU interrupt-enable flag
- exec_long  in  1  current instruction needs two execute cycles (long branch/skip)
- idle_req  in  1  current instruction is IDL
- sc  out  2  state code: 0 fetch, 1 execute, 2 DMA, 3 interrupt
- tpa  out  1  timing pulse A
- tpb  out  1  timing pulse B
- dma_in_cycle  out  1  current S2 cycle is DMA-in
- dma_out_cycle  out  1  current S2 cycle is DMA-out
- int_ack  out  1  one-ce pulse at phase 0 of each S3 cycle
- ie_clear  out  1  same timing as int_ack; instructs the CPU to clear IE
- cycle_end  out  1  high during the last phase (PHASES-1) of every cycle
- idle  out  1  sequencer is parked in idle execute cycles

## Operation
- The phase counter counts 0..PHASES-1 on ce and wraps to 0. Nothing advances without ce.
- At phase TPB_PHASE with ce, the block registers dma_in_req=~dma_in_n, dma_out_req=~dma_out_n and int_req=~int_n&ie.
- At the wrap, the next sc is chosen from current sc and the sampled requests:
  - S0 → S1.
  - S1, exec_long, first execute → S1 (second execute). A long_done flag prevents a third.
  - S1 otherwise: DMA sampled → S2; else int_req → S3; else idle_req → S1 with idle=1; else → S0.
  - S1 with idle=1: DMA → S2 (idle cleared); int_req → S3 (idle cleared); otherwise stay in S1.
  - S2: DMA still sampled → S2; else int_req → S3; else → S0.
  - S3: DMA → S2; else → S0.
- DMA priority: dma_in over dma_out. DMA always has priority over interrupt.
- dma_in_cycle and dma_out_cycle are latched at entry to S2 and held for the whole cycle. Both are 0 outside S2, and never both 1.
- Requests that deassert before TPB_PHASE are not seen. Requests asserted after TPB_PHASE wait for the next cycle's sample.
- Reset values: phase=0, sc=0, tpa=0, tpb=0, all cycle flags/pulses 0, idle=0, long_done=0, sampled requests 0.
- If reset is asserted mid-cycle, the next clock returns to these values. The first cycle after reset release is S0.

## Timing
- All outputs are registered. sc changes only on the clock edge at which the phase wraps PHASES-1→0, so sc is stable for the whole cycle (the CDP1861 decodes SC with TPA/TPB).
- tpa is high for exactly the ce-period in which phase==TPA_PHASE. tpb behaves the same with TPB_PHASE. They never overlap.
- Decision latency: a request sampled at TPB of cycle N takes effect in cycle N+1, never later.
- A DMA request held continuously produces back-to-back S2 cycles with no S0 in between. Instruction flow resumes at S0 after the last S2.
- With int_n held low and ie=1, exactly one S3 is issued. After that, ie is expected to be low (the CPU obeys ie_clear) and no further S3 occurs until ie rises again.

## Structure
- Shared package cdp1802_pkg holds the SC encoding constants (SC_FETCH=2'd0, SC_EXEC=2'd1, SC_DMA=2'd2, SC_INT=2'd3) and the default PHASES/TPA_PHASE/TPB_PHASE. The CPU core and the CDP1861 block import the same constants.
- One natural sub-module: cdp1802_phase_gen (phase counter, tpa, tpb, cycle_end). The next-state arbitration stays in the top module.

## Test plan
- Reset, then ce=1 constantly with no requests → sc alternates 0,1,0,1 every 8 clocks. tpa is high at phase 1 and tpb at phase 6, each exactly one clock per cycle.
- dma_out_n low from fetch TPB through three cycles → after the execute, sc=2 for three consecutive cycles with dma_out_cycle=1, then sc=0.
- int_n low, ie=1 during an execute → next sc=3, int_ack and ie_clear pulse at its phase 0, then sc=0. With ie=0, no S3 occurs.
- dma_in_n and dma_out_n low simultaneously, plus int_n low → S2 with dma_in_cycle=1 first. S3 follows only after all DMA is gone.
- idle_req=1 → sc holds 1 with idle=1 for 5 cycles. dma_out_n is then pulsed low around TPB → S2, then S0, and idle=0.
- exec_long=1 → two S1 cycles, then S0. Reset asserted at phase 4 of an S2 → sc=0, tpa=tpb=0, dma_out_cycle=0 on the next clock.
